// File: rtl/cmd.sv
// Command opcode table; index i of DISPATCH_OPCODES selects sub-command i.
package cmd;
    typedef logic [7:0] opcode_t;
    localparam int NUM_OPCODES = 4;
    localparam opcode_t DISPATCH_OPCODES [NUM_OPCODES] = '{8'h52, 8'h57, 8'h43, 8'h46};
endpackage

// File: rtl/control_cmd_dispatch_pkg.sv
// Dispatcher state encoding and opcode lookup helper.
package control_cmd_dispatch_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} dispatch_state_t;

    localparam int IDX_W = $clog2(cmd::NUM_OPCODES);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } decode_t;

    // Lowest table index wins if an opcode is listed twice.
    function automatic decode_t decode_opcode(cmd::opcode_t b);
        decode_t d;
        d = '0;
        for (int i = cmd::NUM_OPCODES - 1; i >= 0; i--) begin
            if (b == cmd::DISPATCH_OPCODES[i]) begin
                d.hit = 1'b1;
                d.idx = IDX_W'(i);
            end
        end
        return d;
    endfunction
endpackage

// File: rtl/types.sv
// Shared framebuffer types used by the command modules.
package types;
    localparam int FB_ADDR_W       = 16;
    localparam int BYTES_PER_PIXEL = 3;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
endpackage

// File: rtl/control_cmd_dispatch_if.sv
// Byte stream, sub-command strobes and framebuffer write port around the dispatcher.
interface control_cmd_dispatch_if #(parameter int NUM_CMDS = 4);
    logic [7:0]                        data_in;
    logic                              data_valid;
    logic [NUM_CMDS-1:0]               sub_enable;
    logic [7:0]                        sub_data;
    logic [NUM_CMDS-1:0]               sub_reset;
    logic [NUM_CMDS-1:0]               sub_done;
    types::fb_addr_t [NUM_CMDS-1:0]    sub_addr;
    logic [NUM_CMDS-1:0][7:0]          sub_do;
    logic [NUM_CMDS-1:0]               sub_we;
    logic [NUM_CMDS-1:0]               sub_as;
    types::fb_addr_t                   fb_addr;
    logic [7:0]                        fb_do;
    logic                              fb_we;
    logic                              fb_as;

    modport slave (
        input  data_in, data_valid, sub_done, sub_addr, sub_do, sub_we, sub_as,
        output sub_enable, sub_data, sub_reset, fb_addr, fb_do, fb_we, fb_as
    );

    modport master (
        output data_in, data_valid, sub_done, sub_addr, sub_do, sub_we, sub_as,
        input  sub_enable, sub_data, sub_reset, fb_addr, fb_do, fb_we, fb_as
    );
endinterface

// File: rtl/dispatch_timeout.sv
// Inter-byte stall counter: clears on clr, counts while en, flags the last count.
module dispatch_timeout #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && !clr && (count == LAST);
endmodule

// File: rtl/control_cmd_dispatch.sv
// Routes each command's payload bytes to one sub-command and muxes its framebuffer port.
module control_cmd_dispatch
    import control_cmd_dispatch_pkg::*;
#(
    parameter int NUM_CMDS       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    control_cmd_dispatch_if.slave       bus,
    output logic                        busy,
    output logic [$clog2(NUM_CMDS)-1:0] active_cmd,
    output logic                        err_opcode,
    output logic                        err_timeout
);
    localparam int SEL_W = $clog2(NUM_CMDS);

    dispatch_state_t     state, state_nxt;
    logic [SEL_W-1:0]    sel;
    logic                pend_vld;
    cmd::opcode_t        pend_byte;
    logic [NUM_CMDS-1:0] prev_as;
    logic                as_armed;
    logic [NUM_CMDS-1:0] sel_onehot;
    decode_t             dec;
    cmd::opcode_t        dec_byte;
    logic                dec_vld, dec_hit, done_sel;
    logic                byte_fwd, pend_load, tmo_fire, fb_live;
    logic                tmo_clr, tmo_en, tmo_hit;

    dispatch_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_hit)
    );

    // A fresh byte in IDLE supersedes whatever sits in the pending slot.
    always_comb begin
        dec_vld    = bus.data_valid || pend_vld;
        dec_byte   = bus.data_valid ? bus.data_in : pend_byte;
        dec        = decode_opcode(dec_byte);
        dec_hit    = dec.hit && (int'(dec.idx) < NUM_CMDS);
        done_sel   = bus.sub_done[sel];
        sel_onehot = NUM_CMDS'(1) << sel;
        tmo_en     = (state == ST_ACTIVE);
        tmo_clr    = (state != ST_ACTIVE) || bus.data_valid;
        state_nxt  = state;
        byte_fwd   = 1'b0;
        pend_load  = 1'b0;
        tmo_fire   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dec_vld && dec_hit) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (done_sel) begin
                    state_nxt = ST_DRAIN;
                    pend_load = bus.data_valid;
                end else begin
                    byte_fwd = bus.data_valid;
                    if (tmo_hit) begin
                        tmo_fire  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_IDLE;
                pend_load = bus.data_valid;
            end
            default: state_nxt = ST_IDLE;
        endcase
        fb_live = (state != ST_IDLE) && (state_nxt != ST_IDLE);
    end

    assign busy       = (state != ST_IDLE);
    assign active_cmd = busy ? sel : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            sel            <= '0;
            pend_vld       <= 1'b0;
            pend_byte      <= '0;
            prev_as        <= '0;
            as_armed       <= 1'b0;
            err_opcode     <= 1'b0;
            err_timeout    <= 1'b0;
            bus.sub_enable <= '0;
            bus.sub_data   <= '0;
            bus.sub_reset  <= '0;
            bus.fb_addr    <= '0;
            bus.fb_do      <= '0;
            bus.fb_we      <= 1'b0;
            bus.fb_as      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && dec_vld && dec_hit) sel <= SEL_W'(dec.idx);

            if (pend_load) begin
                pend_vld  <= 1'b1;
                pend_byte <= bus.data_in;
            end else if (state == ST_IDLE) begin
                pend_vld <= 1'b0;
            end

            err_opcode     <= (state == ST_IDLE) && dec_vld && !dec_hit;
            err_timeout    <= tmo_fire;
            bus.sub_reset  <= tmo_fire ? sel_onehot : '0;
            bus.sub_enable <= byte_fwd ? sel_onehot : '0;
            if (byte_fwd) bus.sub_data <= bus.data_in;

            // First clock after reset only seeds prev_as so a held-high sub_as is not seen as a toggle.
            prev_as  <= bus.sub_as;
            as_armed <= 1'b1;
            if (as_armed) bus.fb_as <= bus.fb_as ^ (bus.sub_as[sel] ^ prev_as[sel]);

            if (fb_live) begin
                bus.fb_addr <= bus.sub_addr[sel];
                bus.fb_do   <= bus.sub_do[sel];
                bus.fb_we   <= bus.sub_we[sel];
            end else begin
                bus.fb_addr <= '0;
                bus.fb_do   <= '0;
                bus.fb_we   <= 1'b0;
            end
        end
    end
endmodule
